// File: rtl/fp_operand_stage.sv
// fp_operand_stage: issue stage in front of the FP add/multiply datapath.
// It accepts an operand pair and an opcode over a valid/ready handshake and
// screens the operands for IEEE-754 single-precision special values.
// Special and illegal cases are resolved here and bypassed.
// All other operations are held on the datapath inputs for an op-dependent
// number of cycles, and then the datapath result is captured.
// The result is returned over a second valid/ready handshake.
//
// Optional build macro: DENORM_FTZ_EN
//   When defined, denormal operands are flushed to a signed zero before they
//   are classified and captured. Denormal datapath results are flushed the
//   same way when they are captured.
//   When undefined, denormals pass through untouched in both directions.

module fp_operand_stage #(
    parameter int unsigned LAT_SUM  = 8,
    parameter int unsigned LAT_MULT = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_op,
    output logic [31:0] dp_operando_a,
    output logic [31:0] dp_operando_b,
    output logic [1:0]  dp_op,
    output logic        dp_reset,
    input  logic [31:0] dp_resultado,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_special
);

    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [1:0]  OP_SUM     = 2'b00;
    localparam logic [7:0]  LAT_SUM_C  = 8'(LAT_SUM);
    localparam logic [7:0]  LAT_MULT_C = 8'(LAT_MULT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Classification and bypass helpers
    // ------------------------------------------------------------------
    function automatic logic is_nan(input logic [31:0] v);
        is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        is_inf = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] v);
        is_zero = (v[30:23] == 8'h00) && (v[22:0] == 23'd0);
    endfunction

    // Flushes a denormal to a signed zero when FTZ is built in.
    // Otherwise the value passes through unchanged.
    function automatic logic [31:0] ftz(input logic [31:0] v);
`ifdef DENORM_FTZ_EN
        if (v[30:23] == 8'h00) begin
            ftz = {v[31], 31'd0};
        end else begin
            ftz = v;
        end
`else
        ftz = v;
`endif
    endfunction

    // The operation is special when the datapath does not need to run.
    function automatic logic is_special(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0]  op);
        is_special = op[1] || is_nan(a) || is_nan(b) || is_inf(a) ||
                     is_inf(b) || is_zero(a) || is_zero(b);
    endfunction

    // Computes the bypass result. Rules are checked in priority order.
    // The final else branches are reached only for non-special inputs,
    // which never select this result.
    function automatic logic [31:0] bypass(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [1:0]  op);
        logic sa;
        logic sb;
        sa = a[31];
        sb = b[31];
        if (op[1]) begin
            bypass = QNAN;
        end else if (is_nan(a) || is_nan(b)) begin
            bypass = QNAN;
        end else if (op == OP_SUM) begin
            if (is_inf(a) && is_inf(b) && (sa != sb)) begin
                bypass = QNAN;
            end else if (is_inf(a)) begin
                bypass = a;
            end else if (is_inf(b)) begin
                bypass = b;
            end else if (is_zero(a) && is_zero(b)) begin
                bypass = {sa & sb, 31'd0};
            end else if (is_zero(a)) begin
                bypass = b;
            end else if (is_zero(b)) begin
                bypass = a;
            end else begin
                bypass = QNAN;
            end
        end else begin
            if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) begin
                bypass = QNAN;
            end else if (is_inf(a) || is_inf(b)) begin
                bypass = {sa ^ sb, 8'hFF, 23'd0};
            end else if (is_zero(a) || is_zero(b)) begin
                bypass = {sa ^ sb, 31'd0};
            end else begin
                bypass = QNAN;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] res_q, res_d;
    logic        spec_q, spec_d;
    logic        valid_q, valid_d;
    logic        rdy_q, rdy_d;
    logic        dprst_q, dprst_d;

    logic [31:0] a_ftz_s;
    logic [31:0] b_ftz_s;
    logic        special_s;
    logic        accept_s;

    // Reset takes effect on the outputs immediately, without waiting an edge.
    assign in_ready      = rdy_q & ~reset;
    assign dp_reset      = dprst_q | reset;
    assign dp_operando_a = opa_q;
    assign dp_operando_b = opb_q;
    assign dp_op         = op_q;
    assign out_valid     = valid_q;
    assign out_result    = res_q;
    assign out_special   = spec_q;

    assign a_ftz_s   = ftz(in_a);
    assign b_ftz_s   = ftz(in_b);
    assign special_s = is_special(a_ftz_s, b_ftz_s, in_op);
    assign accept_s  = in_valid & in_ready;

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic of the handshake and sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = special_s ? ST_DONE : ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values for the counter, the datapath inputs, the result and the flags.
    always_comb begin
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;
        res_d   = res_q;
        spec_d  = spec_q;
        valid_d = (state_d == ST_DONE);
        rdy_d   = (state_d == ST_IDLE);
        dprst_d = (state_d == ST_START);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    opa_d  = a_ftz_s;
                    opb_d  = b_ftz_s;
                    op_d   = in_op;
                    spec_d = special_s;
                    if (special_s) begin
                        res_d = bypass(a_ftz_s, b_ftz_s, in_op);
                    end else begin
                        res_d = res_q;
                    end
                end else begin
                    opa_d = opa_q;
                end
            end
            ST_START: begin
                cnt_d = ((op_q == OP_SUM) ? LAT_SUM_C : LAT_MULT_C) - 8'd1;
            end
            ST_RUN: begin
                if (cnt_q == 8'd0) begin
                    res_d = ftz(dp_resultado);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = 8'd0;
            end
        endcase
    end

    // Data and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= 8'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            op_q    <= 2'b00;
            res_q   <= 32'd0;
            spec_q  <= 1'b0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
            dprst_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            res_q   <= res_d;
            spec_q  <= spec_d;
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            dprst_q <= dprst_d;
        end
    end

endmodule
